// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the core pipeline and the multiply/divide unit.
// Carries the request (funct3, operands, destination) and the regfile write port.
// master = core side, slave = muldiv_unit side.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            wb_wren;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr,
    input  busy, wb_wren, wb_addr, wb_data
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr,
    output busy, wb_wren, wb_addr, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one step per clock.
// Latency: 34 edges from accept to regfile commit (3 for divide-by-zero/overflow, early-out multiply shorter).
// Backpressure: busy is high outside IDLE; start is ignored until the unit returns to IDLE.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply leaves CALC once the multiplier is exhausted).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              skip_q;
  logic [XLEN-1:0]   spec_q;
  logic [CW-1:0]     cnt;

  // multiply datapath
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;

  // divide datapath: quo shifts the dividend out as quotient bits shift in
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;

  logic              wren_q;
  logic [4:0]        waddr_q;
  logic [XLEN-1:0]   wdata_q;

  // request decode
  logic              rs1_signed, rs2_signed, neg1, neg2, res_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   spec_val;

  // iteration and final-value signals
  logic [XLEN:0]     shifted;
  logic              fits;
  logic [XLEN-1:0]   sub;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   qv, rv, result;

  assign bus.busy    = (state != IDLE);
  assign bus.wb_wren = wren_q;
  assign bus.wb_addr = waddr_q;
  assign bus.wb_data = wdata_q;

  // Decode signedness, operand magnitudes and the divide special cases from the live request.
  always_comb begin
    rs1_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    rs2_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
    neg1       = rs1_signed && bus.rs1_data[XLEN-1];
    neg2       = rs2_signed && bus.rs2_data[XLEN-1];
    mag1       = neg1 ? -bus.rs1_data : bus.rs1_data;
    mag2       = neg2 ? -bus.rs2_data : bus.rs2_data;
    // remainder follows the dividend; everything else follows the product of signs
    res_neg    = (bus.funct3[2] && bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
    div_zero   = bus.funct3[2] && (bus.rs2_data == '0);
    div_ovf    = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                 (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
    spec_val   = '0;
    if (div_zero) begin
      spec_val = bus.funct3[1] ? bus.rs1_data : '1;
    end else if (div_ovf) begin
      spec_val = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring-divide step and the sign-corrected final result selection.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor});
    // the true difference is below the divisor, so XLEN bits are enough
    sub     = shifted[XLEN-1:0] - divisor;
    prod    = neg_q ? -acc : acc;
    qv      = neg_q ? -quo : quo;
    rv      = neg_q ? -rem : rem;
    case (op)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = qv;
      default:                result = rv;
    endcase
    if (skip_q) begin
      result = spec_q;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      skip_q  <= 1'b0;
      spec_q  <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op      <= bus.funct3;
            rd_q    <= bus.rd_addr;
            neg_q   <= res_neg;
            skip_q  <= div_zero || div_ovf;
            spec_q  <= spec_val;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, mag1};
            mplier  <= mag2;
            rem     <= '0;
            quo     <= mag1;
            divisor <= mag2;
            state   <= CALC;
          end
        end
        CALC: begin
          // special divide cases leave at the first CALC edge without iterating
          if (skip_q) begin
            state <= FIX;
`ifdef MULDIV_EARLY_OUT_EN
          end else if (!op[2] && (mplier == '0)) begin
            state <= FIX;
`endif
          end else begin
            if (op[2]) begin
              rem <= fits ? sub : shifted[XLEN-1:0];
              quo <= {quo[XLEN-2:0], fits};
            end else begin
              if (mplier[0]) begin
                acc <= acc + mcand;
              end
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(XLEN - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          wdata_q <= result;
          waddr_q <= rd_q;
          wren_q  <= (rd_q != 5'd0);
          state   <= WB;
        end
        default: begin
          wren_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, write-back timing and reset abort.
// Each operation is issued at edge E0 and write-back is observed for 45 edges.
// Expected values are hand-computed constants.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   writes9;
  logic [31:0] rf [0:31];

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple regfile fed by the write-back port
  always @(posedge clk) begin
    if (bus.wb_wren) begin
      rf[bus.wb_addr] <= bus.wb_data;
      if (bus.wb_addr == 5'd9) writes9 <= writes9 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at E0, scramble the inputs afterwards, then watch 45 edges.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat);
    int first;
    int highs;
    logic [31:0] got_data;
    logic [4:0]  got_addr;
    logic        busy1;
    first = -1;
    highs = 0;
    got_data = '0;
    got_addr = '0;
    busy1 = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_addr = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_addr = 5'($urandom);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) busy1 = bus.busy;
      if (bus.wb_wren) begin
        highs++;
        if (first < 0) begin
          first = k;
          got_data = bus.wb_data;
          got_addr = bus.wb_addr;
        end
      end
    end
    chk({tag, " busy_after_E0"}, 32'(busy1), 32'd1);
    chk({tag, " wren_edge"}, 32'(first), 32'(exp_lat));
    if (exp_lat >= 0) begin
      chk({tag, " wren_cycles"}, 32'(highs), 32'd1);
      chk({tag, " data"}, got_data, exp_data);
      chk({tag, " addr"}, 32'(got_addr), 32'(rd));
    end else begin
      chk({tag, " wren_cycles"}, 32'(highs), 32'd0);
    end
    chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int highs;
    checks = 0;
    failures = 0;
    writes9 = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset wren", 32'(bus.wb_wren), 32'd0);
    chk("reset addr", 32'(bus.wb_addr), 32'd0);
    chk("reset data", bus.wb_data, 32'd0);
    rst_n = 1'b1;

    run_op("MUL 7*6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 33);
    chk("rf5", rf[5], 32'd42);
    run_op("MULH -1*-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 33);
    run_op("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);
    run_op("MULHSU -1*2", 3'b010, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF, 33);
    run_op("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD, 33);
    run_op("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 33);
    run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 2);
    run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 5'd11, 32'd5, 2);
    run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 2);
    run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 2);
    run_op("MUL rd0", 3'b000, 32'd2, 32'd2, 5'd0, 32'd0, -1);
`ifdef MULDIV_EARLY_OUT_EN
    run_op("MUL 12345*1", 3'b000, 32'd12345, 32'd1, 5'd14, 32'd12345, 3);
`else
    run_op("MUL 12345*1", 3'b000, 32'd12345, 32'd1, 5'd14, 32'd12345, 33);
`endif

    // Reset abort: MUL 3*3 rd=9 at E0, ignored start with new operands at E10, reset at E15.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd3;
    bus.rd_addr = 5'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd100;
    bus.funct3 = 3'b101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort busy_E10", 32'(bus.busy), 32'd1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort wren", 32'(bus.wb_wren), 32'd0);
    highs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.wb_wren) highs++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.wb_wren) highs++;
    end
    chk("abort no_wren", 32'(highs), 32'd0);
    chk("abort writes9", 32'(writes9), 32'd0);
    run_op("MUL 3*3 post", 3'b000, 32'd3, 32'd3, 5'd9, 32'd9, 33);
    chk("rf9", rf[9], 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
